// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter (8-N-1, or 8-E-1 when
// UART_TX_PARITY_EN is defined). Frames are sent back-to-back while the FIFO
// holds data; the TX pin comes straight from a flop.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | start bit (low) for one bit-time
// DATA   | 8 data bits, LSB first, one bit-time each
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); pops the next byte on its last cycle
module uart_tx_fifo #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_fifo_data_in,
  input  logic       tx_fifo_write_en,
  output logic       uart_tx_pin,
  output logic       tx_fifo_empty,
  output logic       tx_fifo_full,
  output logic       tx_busy,
  output logic       tx_overflow
);

  localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIVISOR);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q, busy_q, overflow_q, overflow_d;
  logic          wr_en, pop;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          pin_q, pin_d;
  logic          baud_last;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  // A write into a full FIFO is dropped even when a pop frees a slot on the same edge.
  always_comb begin
    wr_en      = tx_fifo_write_en && !full_q;
    overflow_d = overflow_q || (tx_fifo_write_en && full_q);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(wr_en) - CW'(pop);
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= tx_fifo_data_in;
  end

  // FIFO pointers, count and flags registered from the next-state count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CW'(FIFO_DEPTH));
      overflow_q <= overflow_d;
      busy_q     <= (state_d != S_IDLE) || (count_d != '0);
    end
  end

  assign baud_last = (baud_q == BW'(BAUD_DIVISOR - 1));

  // Next-state, pop decision and next pin value; the pin is derived from the
  // next state so it changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    if (pop) parity_d = ^mem_q[rd_ptr_q];
`endif

    if (state_d != state_q || baud_last || state_d == S_IDLE) baud_d = '0;
    else                                                      baud_d = baud_q + BW'(1);

    case (state_d)
      S_START:  pin_d = 1'b0;
      S_DATA:   pin_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: pin_d = parity_d;
`endif
      default:  pin_d = 1'b1;
    endcase
  end

  // Transmitter state register; reset drives the pin high asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pin_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign uart_tx_pin   = pin_q;
  assign tx_fifo_empty = empty_q;
  assign tx_fifo_full  = full_q;
  assign tx_busy       = busy_q;
  assign tx_overflow   = overflow_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit half of the UART: buffers bytes written by command/response logic in a small synchronous FIFO and serialises them as 8-N-1 frames (optionally 8-E-1) onto the TX pin. Sits directly downstream of the top-level response sequencer, which pulses `tx_fifo_write_en` once per character. It replaces ad-hoc per-byte busy polling, so a whole response string ("Pass\r\n") can be written back-to-back.

## Interface
- `CLOCK_FREQUENCY`, 27000000: system clock in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s; `BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE` (integer truncation, 234 at defaults, must be ≥ 2).
- `FIFO_DEPTH`, 16: FIFO entries; power of two, 2..256.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_fifo_data_in`  in  8  byte to queue.
- `tx_fifo_write_en`  in  1  one-cycle write strobe; byte captured on the rising edge where high.
- `uart_tx_pin`  out  1  serial line, idle high.
- `tx_fifo_empty`  out  1  FIFO holds no bytes.
- `tx_fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `tx_busy`  out  1  frame in progress or FIFO non-empty.
- `tx_overflow`  out  1  sticky; set when a write is dropped, cleared only by reset.

## Operation
- Reset values: `uart_tx_pin`=1, `tx_fifo_empty`=1, `tx_fifo_full`=0, `tx_busy`=0, `tx_overflow`=0, pointers and count 0, FSM IDLE.
- FIFO: write pointer, read pointer, and `log2(FIFO_DEPTH)+1`-bit count; pointers wrap modulo `FIFO_DEPTH`. Flags are registered from the next-state count.
- Write while full: byte dropped, contents unchanged, `tx_overflow` set. This holds even if a pop occurs on the same edge.
- Write and pop on the same edge when not full: both take effect and the count is unchanged.
- FSM states:
  - IDLE: pin=1. When FIFO is non-empty, pop the head into an 8-bit shift register, go to START.
  - START: pin=0 for `BAUD_DIVISOR` cycles, then go to DATA with bit index 0.
  - DATA: pin=shift[0], LSB first. Each bit lasts `BAUD_DIVISOR` cycles, then shift right. After bit 7 go to PARITY if enabled, otherwise STOP.
  - PARITY: pin = XOR of the 8 data bits (even parity), for `BAUD_DIVISOR` cycles, then STOP.
  - STOP: pin=1 for `BAUD_DIVISOR` cycles. On the last cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..`BAUD_DIVISOR`-1 and clears on every state change.
- `tx_busy` = (state≠IDLE) | !`tx_fifo_empty`, registered.
- Reset asserted mid-frame: pin returns high immediately (asynchronous), FIFO is flushed, and the partial frame is abandoned.

## Timing
- Write strobe at edge k: `tx_fifo_empty` falls after edge k. The FSM pops at edge k+1, and `uart_tx_pin` falls at edge k+1.
- Frame length: 10×`BAUD_DIVISOR` cycles (11× with parity). At defaults this is 2340 cycles (86.67 µs).
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle.
- `uart_tx_pin` is a flop output (glitch-free).
- Throughput: the FIFO accepts one byte per cycle; the line drains one byte per frame.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and frames are 8-E-1 (11 bit-times).
- `UART_TX_PARITY_EN` undefined: the PARITY state and XOR logic are absent and frames are 8-N-1 (10 bit-times).
- The receive side must use the same setting; this is enforced at system level, not in this block.

## Test plan
- Single byte, defaults, no parity: write 0x55 → pin low at the edge after the write. Bits then read 1,0,1,0,1,0,1,0 at 234-cycle intervals, stop high, then IDLE; `tx_busy` falls after 2340 cycles.
- String burst: write "Pass\r\n" (0x50,0x61,0x73,0x73,0x0D,0x0A) on 6 consecutive cycles → 6 contiguous frames with no idle gap; the decoded bytes match in order; `tx_fifo_empty` rises at the final pop.
- Overflow: with one frame active, write 17 bytes (FIFO_DEPTH=16) → `tx_fifo_full`=1 after the 16th write, the 17th byte is dropped, `tx_overflow`=1, and the 16 queued bytes are sent intact.
- Wrap-around: send 40 bytes in bursts of 10 → all 40 decoded correctly across pointer wrap.
- Reset mid-frame: drop `reset_n` during DATA bit 3 of 0xA5 → pin high in the same cycle and all outputs at reset values. After release, a write of 0x3C transmits cleanly.
- With `UART_TX_PARITY_EN` defined: write 0x07 → parity bit 1. Write 0x03 → parity bit 0. Each frame is 2574 cycles.
